// File: rtl/reg_file_16x16_pkg.sv
// Shared sizing and special register indices for the 16x16 register file.
package reg_file_16x16_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_ZERO_REG = 0;
  localparam int DEF_LINK_REG = 15;

  typedef logic [DEF_ADDR_W-1:0] reg_index_t;

  localparam reg_index_t ZERO_REG = reg_index_t'(DEF_ZERO_REG);
  localparam reg_index_t LINK_REG = reg_index_t'(DEF_LINK_REG);

endpackage

// File: rtl/reg_file_16x16_read_port.sv
// One combinational read port: index mux, zero-register forcing and, when
// REGFILE_BYPASS_EN is defined, same-cycle write-through from the write ports.
module reg_file_read_port
  import reg_file_16x16_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
`endif
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
`endif

  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // Link data has priority, matching the commit order of a collision.
    if (link_en && (addr == LINK_IDX)) begin
      data = link_data;
    end else if (wr_en && (addr == wr_addr)) begin
      data = wr_data;
    end else begin
      data = regs[addr];
    end
`endif
    if (reset || (addr == ZERO_IDX)) begin
      data = '0;
    end else begin
      data = data;
    end
  end

endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 general-purpose register file: two combinational reads, a main write
// port and a link write port; optional write-through via REGFILE_BYPASS_EN.
module reg_file_16x16
  import reg_file_16x16_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              linkWrite,
  input  logic [DATA_W-1:0] linkData,
  output logic              writeCollision
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              collision_q;
  logic              collision_d;
  logic              wr_en_s;

  assign wr_en_s = write && (writeAddr != ZERO_IDX);

  // Link write is applied last so it wins a collision at LINK_REG.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (linkWrite && (ADDR_W'(i) == LINK_IDX)) begin
        regs_d[i] = linkData;
      end else if (wr_en_s && (ADDR_W'(i) == writeAddr)) begin
        regs_d[i] = writeData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    regs_d[ZERO_IDX] = '0;
    collision_d = write && linkWrite && (writeAddr == LINK_IDX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      collision_q <= collision_d;
    end
  end

  assign writeCollision = collision_q;

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .LINK_REG(LINK_REG)
  ) u_read_a (
    .reset    (reset),
    .addr     (readAddrA),
    .regs     (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en    (wr_en_s),
    .wr_addr  (writeAddr),
    .wr_data  (writeData),
    .link_en  (linkWrite),
    .link_data(linkData),
`endif
    .data     (dataA)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .LINK_REG(LINK_REG)
  ) u_read_b (
    .reset    (reset),
    .addr     (readAddrB),
    .regs     (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en    (wr_en_s),
    .wr_addr  (writeAddr),
    .wr_data  (writeData),
    .link_en  (linkWrite),
    .link_data(linkData),
`endif
    .data     (dataB)
  );

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- Processor general-purpose register file: 16 entries × 16 bits, built from the same per-register storage style as the datapath's standalone 16-bit registers.
- Sits between the write-back mux (upstream) and the ALU operand inputs (downstream).
- Two combinational read ports and one synchronous main write port.
- A dedicated link-write port lets jump-and-link write the return address in the same cycle as a normal write-back.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register index width; depth = 2**ADDR_W
ZERO_REG, 0, index hardwired to zero; writes to it are discarded
LINK_REG, 15, index targeted by the link-write port

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all registers
readAddrA  input  ADDR_W  read port A index
readAddrB  input  ADDR_W  read port B index
dataA  output  DATA_W  contents of readAddrA (combinational)
dataB  output  DATA_W  contents of readAddrB (combinational)
write  input  1  main write enable
writeAddr  input  ADDR_W  main write index
writeData  input  DATA_W  main write data
linkWrite  input  1  link write enable; target is LINK_REG
linkData  input  DATA_W  link write data (return PC)
writeCollision  output  1  registered flag: both ports hit LINK_REG in the previous cycle

Behaviour:
- Reset (asynchronous, active-high):
  - All entries go to 0 immediately.
  - writeCollision goes to 0.
  - While reset is high, dataA and dataB read 0 and writes are ignored.
  - Reset asserted mid-cycle wins over any concurrent write.
  - Deassertion takes effect at the next clock edge.
- Read ports:
  - Purely combinational, zero-cycle latency.
  - Reading ZERO_REG always returns 0, whatever was written to it.
- Main write:
  - On a clock rising edge with write=1 and writeAddr != ZERO_REG, the entry takes writeData.
  - The new value is visible on the read ports after that edge.
  - write=1 with writeAddr == ZERO_REG is a no-op.
- Link write:
  - On a clock rising edge with linkWrite=1, LINK_REG takes linkData.
- Simultaneous writes:
  - Different targets: both commit on the same edge.
  - Both target LINK_REG: linkData wins, and writeCollision is 1 for exactly the following cycle (registered, one-cycle pulse).
  - writeCollision is 0 in all other cycles.
- Read during write (same cycle, same index): read ports return the OLD value unless bypass is compiled in (see Optional Feature).
- Address wrap: all indices are exactly ADDR_W bits, so no out-of-range case exists.
- Storage is flops only. No X may appear on any output after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-through. If a read address matches an enabled write target, the read port returns the data being written this cycle.
  - On a link/main collision at LINK_REG, the bypass returns linkData.
  - Reads of ZERO_REG still return 0.
  - The bypass is combinational from writeData/linkData to dataA/dataB.
- Not defined: reads return stored contents only; no combinational path from write data to read data.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - ZERO_REG and LINK_REG constants.
  - A reg_index_t typedef for ADDR_W-bit indices.
- One natural sub-module: reg_file_read_port, one instance per read port. It contains the read mux, the zero-register forcing, and (under REGFILE_BYPASS_EN) the bypass compare/select.
- Write decode and storage stay in the top module.

Test Plan:
1. Assert reset with prior contents nonzero → all reads return 0x0000 immediately and writeCollision=0; after deassert, read of r3 = 0x0000.
2. write=1, writeAddr=5, writeData=0xBEEF, then readAddrA=5 and readAddrB=5 next cycle → dataA=dataB=0xBEEF.
3. write=1, writeAddr=0, writeData=0x1234 → read of r0 returns 0x0000 on the next and all later cycles.
4. Same edge: write=1, writeAddr=15, writeData=0xAAAA, linkWrite=1, linkData=0x0042 → r15=0x0042; writeCollision=1 for one cycle, then 0.
5. Same edge: write=1, writeAddr=7, writeData=0x0101, linkWrite=1, linkData=0x0200 → r7=0x0101 and r15=0x0200; writeCollision stays 0.
6. Read r9 (holding 0x1111) while writing r9=0x2222 in the same cycle → dataA=0x1111 without the macro, 0x2222 with REGFILE_BYPASS_EN; 0x2222 in both builds after the edge.
